// File: rtl/neighbor_cell_scheduler.sv
// Neighbor-cell sweep sequencer for one home cell: walks the 3x3x3 local cell-ID space and issues
// one request per neighbor with periodic-wrapped global IDs. Define HALF_SHELL_EN for the k=13..26 sweep.

module ncs_axis #(
    parameter int GCELL = 0,
    parameter int DIM   = 3
) (
    input  logic [1:0] cid,
    output logic [2:0] gcid,
    output logic       wrap_lo,
    output logic       wrap_hi
);
    // With DIM=1 both neighbors collapse onto 0 and both wrap flags apply.
    localparam logic [2:0] G_HOME = 3'(GCELL);
    localparam logic [2:0] G_DN   = (GCELL == 0) ? 3'(DIM - 1) : 3'(GCELL - 1);
    localparam logic [2:0] G_UP   = (GCELL == DIM - 1) ? 3'd0 : 3'(GCELL + 1);
    localparam logic       WL     = (GCELL == 0);
    localparam logic       WH     = (GCELL == DIM - 1);

    always_comb begin
        gcid    = '0;
        wrap_lo = 1'b0;
        wrap_hi = 1'b0;
        case (cid)
            2'b01: begin gcid = G_DN; wrap_lo = WL; end
            2'b10: gcid = G_HOME;
            2'b11: begin gcid = G_UP; wrap_hi = WH; end
            default: gcid = '0;
        endcase
    end
endmodule

module neighbor_cell_scheduler #(
    parameter int GCELL_X = 0,
    parameter int GCELL_Y = 0,
    parameter int GCELL_Z = 0,
    parameter int DIM_X   = 3,
    parameter int DIM_Y   = 3,
    parameter int DIM_Z   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [4:0] o_idx,
    output logic [1:0] o_cid_x,
    output logic [1:0] o_cid_y,
    output logic [1:0] o_cid_z,
    output logic [2:0] o_gcid_x,
    output logic [2:0] o_gcid_y,
    output logic [2:0] o_gcid_z,
    output logic [2:0] o_wrap_lo,
    output logic [2:0] o_wrap_hi
);
`ifdef HALF_SHELL_EN
    localparam logic [4:0] K_FIRST = 5'd13;
`else
    localparam logic [4:0] K_FIRST = 5'd0;
`endif
    localparam logic [4:0] K_LAST = 5'd26;
    localparam int GC[3] = '{GCELL_X, GCELL_Y, GCELL_Z};
    localparam int DM[3] = '{DIM_X, DIM_Y, DIM_Z};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t          state, state_nx;
    logic [4:0]      k, k_nx;
    logic [2:0][1:0] cid_nx;
    logic [2:0][2:0] gcid_nx;
    logic [2:0]      wlo_nx, whi_nx;

    always_comb begin
        state_nx = state;
        k_nx     = k;
        case (state)
            S_IDLE: if (i_start) begin
                state_nx = S_ISSUE;
                k_nx     = K_FIRST;
            end
            S_ISSUE: if (i_ready) begin
                if (k == K_LAST) state_nx = S_DONE;
                else             k_nx     = k + 5'd1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Decode next k so the payload registers line up with the registered valid.
    always_comb begin
        cid_nx[0] = 2'(k_nx % 5'd3) + 2'd1;
        cid_nx[1] = 2'((k_nx / 5'd3) % 5'd3) + 2'd1;
        cid_nx[2] = 2'(k_nx / 5'd9) + 2'd1;
    end

    for (genvar a = 0; a < 3; a++) begin : g_axis
        ncs_axis #(.GCELL(GC[a]), .DIM(DM[a])) u_axis (
            .cid     (cid_nx[a]),
            .gcid    (gcid_nx[a]),
            .wrap_lo (wlo_nx[a]),
            .wrap_hi (whi_nx[a])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_valid   <= 1'b0;
            o_idx     <= '0;
            o_cid_x   <= '0;
            o_cid_y   <= '0;
            o_cid_z   <= '0;
            o_gcid_x  <= '0;
            o_gcid_y  <= '0;
            o_gcid_z  <= '0;
            o_wrap_lo <= '0;
            o_wrap_hi <= '0;
        end else begin
            state   <= state_nx;
            k       <= k_nx;
            o_busy  <= (state_nx != S_IDLE);
            o_done  <= (state_nx == S_DONE);
            o_valid <= (state_nx == S_ISSUE);
            // Payload only moves while issuing; it holds through backpressure and idle.
            if (state_nx == S_ISSUE) begin
                o_idx     <= k_nx;
                o_cid_x   <= cid_nx[0];
                o_cid_y   <= cid_nx[1];
                o_cid_z   <= cid_nx[2];
                o_gcid_x  <= gcid_nx[0];
                o_gcid_y  <= gcid_nx[1];
                o_gcid_z  <= gcid_nx[2];
                o_wrap_lo <= wlo_nx;
                o_wrap_hi <= whi_nx;
            end
        end
    end
endmodule

// File: tb/tb_neighbor_cell_scheduler.sv
// Bench for neighbor_cell_scheduler: four instances with different home cells / dims share one
// stimulus stream; a modulo-arithmetic reference model is compared every cycle.

module tb_neighbor_cell_scheduler;
`ifdef HALF_SHELL_EN
    localparam int K_FIRST = 13;
    localparam int BP_K    = 18;
    localparam int RST_K   = 20;
`else
    localparam int K_FIRST = 0;
    localparam int BP_K    = 5;
    localparam int RST_K   = 10;
`endif
    localparam int K_COUNT = 27 - K_FIRST;
    localparam int GCX[4] = '{1, 0, 0, 2};
    localparam int GCY[4] = '{1, 3, 0, 2};
    localparam int GCZ[4] = '{1, 0, 0, 2};
    localparam int DMS[4] = '{4, 4, 1, 3};

    logic clk = 0, rst = 1, i_start = 0, i_ready = 1;
    logic       busy[4], done[4], valid[4];
    logic [4:0] idx[4];
    logic [1:0] cx[4], cy[4], cz[4];
    logic [2:0] gx[4], gy[4], gz[4], wlo[4], whi[4];
    logic [25:0] pay[4];

    int cyc = 0, checks = 0, failures = 0, acc_cnt = 0;
    int m_ph = 0, m_k = 0;
    bit m_zero = 1;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        neighbor_cell_scheduler #(
            .GCELL_X(GCX[i]), .GCELL_Y(GCY[i]), .GCELL_Z(GCZ[i]),
            .DIM_X(DMS[i]), .DIM_Y(DMS[i]), .DIM_Z(DMS[i])
        ) u_dut (
            .clk(clk), .rst(rst), .i_start(i_start), .o_busy(busy[i]), .o_done(done[i]),
            .o_valid(valid[i]), .i_ready(i_ready), .o_idx(idx[i]),
            .o_cid_x(cx[i]), .o_cid_y(cy[i]), .o_cid_z(cz[i]),
            .o_gcid_x(gx[i]), .o_gcid_y(gy[i]), .o_gcid_z(gz[i]),
            .o_wrap_lo(wlo[i]), .o_wrap_hi(whi[i])
        );
        assign pay[i] = {idx[i], cx[i], cy[i], cz[i], gx[i], gy[i], gz[i], wlo[i], whi[i]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int gcell(input int i, input int a);
        return (a == 0) ? GCX[i] : (a == 1) ? GCY[i] : GCZ[i];
    endfunction

    // Reference payload: offset in {-1,0,+1}, global = (home+offset) mod DIM.
    function automatic logic [25:0] exp_pay(input int k, input int i);
        int c[3];
        int g[3];
        logic [2:0] lo, hi;
        c[0] = k % 3; c[1] = (k / 3) % 3; c[2] = k / 9;
        for (int a = 0; a < 3; a++) begin
            int v;
            v = gcell(i, a) + c[a] - 1;
            lo[a] = (v < 0);
            hi[a] = (v >= DMS[i]);
            g[a] = (v + DMS[i]) % DMS[i];
        end
        return {5'(k), 2'(c[0] + 1), 2'(c[1] + 1), 2'(c[2] + 1),
                3'(g[0]), 3'(g[1]), 3'(g[2]), lo, hi};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && valid[0] && i_ready) acc_cnt = acc_cnt + 1;
        if (rst) begin
            m_ph = 0; m_k = 0; m_zero = 1;
        end else begin
            case (m_ph)
                0: if (i_start) begin m_ph = 1; m_k = K_FIRST; m_zero = 0; end
                1: if (i_ready) begin if (m_k == 26) m_ph = 2; else m_k = m_k + 1; end
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("valid%0d", i), 32'(valid[i]), 32'(m_ph == 1));
                chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_ph != 0));
                chk($sformatf("done%0d", i), 32'(done[i]), 32'(m_ph == 2));
                if (m_ph == 1) chk($sformatf("payload%0d", i), 32'(pay[i]), 32'(exp_pay(m_k, i)));
                else if (m_zero) chk($sformatf("payload_zero%0d", i), 32'(pay[i]), 32'd0);
            end
            // Hand-computed anchors for the model.
            if (valid[0] && idx[0] == 5'd26) chk("A_k26_gcid", {gx[0], gy[0], gz[0]}, 9'o222);
            if (valid[1] && idx[1] == 5'd26) begin
                chk("B_k26_gcid", {gx[1], gy[1], gz[1]}, 9'o101);
                chk("B_k26_wrap", {wlo[1], whi[1]}, 6'b000_010);
            end
            if (valid[2]) chk("C_gcid_zero", {gx[2], gy[2], gz[2]}, 9'o000);
            if (valid[3] && idx[3] == 5'd13) chk("D_k13_gcid", {gx[3], gy[3], gz[3]}, 9'o222);
            if (valid[3] && idx[3] == 5'd14) begin
                chk("D_k14_gcid", {gx[3], gy[3], gz[3]}, 9'o022);
                chk("D_k14_wrap", {wlo[3], whi[3]}, 6'b000_001);
            end
`ifndef HALF_SHELL_EN
            if (valid[0] && idx[0] == 5'd0) begin
                chk("A_k0_gcid", {gx[0], gy[0], gz[0]}, 9'o000);
                chk("A_k0_wrap", {wlo[0], whi[0]}, 6'b0);
                chk("B_k0_gcid", {gx[1], gy[1], gz[1]}, 9'o323);
                chk("B_k0_wrap", {wlo[1], whi[1]}, 6'b101_000);
                chk("C_k0_wrap_lo", 32'(wlo[2]), 32'b111);
            end
`endif
        end
    end

    // Called at a negedge; returns at the negedge of the o_done cycle.
    task automatic run_sweep(input string name, input int exp_done, input bit bp, input bit extra);
        int s, stall;
        bit seen, bp_fired;
        s = cyc; acc_cnt = 0; stall = 0; seen = 0; bp_fired = 0;
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        chk({name, "_first_idx"}, 32'(idx[0]), 32'(K_FIRST));
        for (int n = 0; n < 200 && !seen; n++) begin
            if (done[0]) begin
                seen = 1;
                chk({name, "_done_cycle"}, 32'(cyc - s), 32'(exp_done));
                chk({name, "_accepts"}, 32'(acc_cnt), 32'(K_COUNT));
            end else begin
                i_start = extra && (n == 3);
                if (stall > 0) begin
                    chk({name, "_hold_idx"}, 32'(idx[0]), 32'(BP_K));
                    stall--;
                    if (stall == 0) i_ready = 1;
                end else if (bp && !bp_fired && valid[0] && idx[0] == 5'(BP_K)) begin
                    i_ready = 0; stall = 3; bp_fired = 1;
                end
                @(negedge clk);
            end
        end
        i_start = 0; i_ready = 1;
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1; i_start = 0; i_ready = 1;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(valid[0]), 32'd0);
        chk("reset_cid", {cx[0], cy[0], cz[0]}, 6'b0);
        rst = 0;
        @(negedge clk);

        run_sweep("plain", K_COUNT + 1, 0, 0);
        // Start during DONE must be dropped.
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        chk("start_in_done_ignored", 32'(valid[0]), 32'd0);
        // Back-to-back: this cycle is the earliest legal restart.
        run_sweep("bp_extra_start", K_COUNT + 4, 1, 1);
        repeat (3) @(negedge clk);

        // Mid-sweep reset.
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        for (int n = 0; n < 60 && !(valid[0] && idx[0] == 5'(RST_K)); n++) @(negedge clk);
        chk("reached_rst_k", 32'(idx[0]), 32'(RST_K));
        rst = 1;
        @(negedge clk);
        chk("rst_valid_drop", 32'(valid[0]), 32'd0);
        chk("rst_done_none", 32'(done[0]), 32'd0);
        chk("rst_payload_zero", 32'(pay[0]), 32'd0);
        rst = 0;
        repeat (4) @(negedge clk);
        run_sweep("restart", K_COUNT + 1, 0, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/neighbor_cell_scheduler.md
# neighbor_cell_scheduler

Sequences the neighbor-cell sweep for one home cell of the MD force pipeline: on a start pulse it walks the 3x3x3 local cell-ID space (or the half shell) in fixed order and issues one request per neighbor cell. Each request carries the local 2-bit cell IDs and the periodic-wrapped global cell IDs. Requests are consumed by the position-cache read front end through a valid/ready handshake. One instance sits per home cell, between the force-evaluation controller and the cell memories.

## Interface
Parameters:
- GCELL_X / GCELL_Y / GCELL_Z, default 0: global ID of the home cell per dimension, GLOBAL_CELL_ID_WIDTH (3) bits.
- DIM_X / DIM_Y / DIM_Z, default 3: global cell count per dimension, legal range 1..8.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  sweep request pulse; sampled only in IDLE.
- o_busy  out  1  high in ISSUE and DONE.
- o_done  out  1  one-cycle pulse after the last accepted request.
- o_valid  out  1  request valid.
- i_ready  in  1  consumer accepts the request.
- o_idx  out  5  linear neighbor index k, 0..26.
- o_cid_x / o_cid_y / o_cid_z  out  2 each  local cell ID: 01 = -1, 10 = home, 11 = +1.
- o_gcid_x / o_gcid_y / o_gcid_z  out  3 each  wrapped global cell ID.
- o_wrap_lo  out  3  bit0 = x, bit1 = y, bit2 = z; set when a -1 offset wrapped to DIM-1.
- o_wrap_hi  out  3  same bit order; set when a +1 offset wrapped to 0.

## Operation
- Index decode: cid_x = k%3+1, cid_y = (k/3)%3+1, cid_z = k/9+1, so x varies fastest. k=13 is the home cell (10,10,10).
- gcid per dimension:
  - 10 -> GCELL.
  - 01 -> GCELL-1; if GCELL==0, gives DIM-1 and sets wrap_lo.
  - 11 -> GCELL+1; if GCELL==DIM-1, gives 0 and sets wrap_hi.
  - With DIM=1, every offset maps to 0, and the matching wrap bit is set for 01 and 11.
  - Duplicate global IDs (DIM<=2) are not removed.
- The sweep runs k = K_FIRST..26 in steps of 1. K_FIRST is 0 for a full shell and 13 for a half shell (see Configuration).
- State machine:
  - IDLE: o_valid=0, o_busy=0. On i_start, load k=K_FIRST and go to ISSUE.
  - ISSUE: o_valid=1. On o_valid&&i_ready: if k==26, go to DONE; otherwise k <= k+1 and stay in ISSUE.
  - DONE: o_done=1, o_valid=0. Return to IDLE unconditionally.
- i_start in ISSUE or DONE is ignored and is not queued.
- While o_valid=1 and i_ready=0, all payload outputs (o_idx, o_cid_*, o_gcid_*, o_wrap_*) hold stable.
- Payload outputs are don't-care when o_valid=0 but are driven from the registered k.

## Timing
- Every output is a register. The gcid and wrap values are computed from the next-k value and registered with it.
- i_start high at edge t: o_valid=1 with k=K_FIRST from edge t+1.
- With i_ready held high, one request is accepted per cycle:
  - Full shell: 27 requests in cycles t+1..t+27, o_done at t+28, IDLE at t+29.
  - Half shell: 14 requests, o_done at t+15.
- The earliest next i_start is accepted in the cycle after o_done, giving a 2-cycle gap between sweeps.
- Reset values: state IDLE, k=0, and every output 0, including o_cid_* = 00.
- rst asserted mid-sweep aborts the sweep on the next edge. o_valid drops and no o_done is produced.
- rst and i_start in the same cycle: rst wins.

## Configuration
- HALF_SHELL_EN:
  - Defined: K_FIRST=13, so the sweep issues the home cell plus the 13 upper-half neighbors (k=13..26), 14 requests.
  - Undefined: K_FIRST=0, so the sweep issues all 27 cells.
  - The index decode, gcid rules and handshake are identical in both builds.

## Test plan
- Full shell, DIM=4, GCELL=(1,1,1), i_ready=1, start at cycle 0:
  - Requests k=0..26 are issued in cycles 1..27, with o_done at cycle 28.
  - k=0 gives gcid (0,0,0); k=26 gives (2,2,2).
  - No wrap bits are set.
- Wrap corners, DIM=4, GCELL=(0,3,0):
  - k=0 gives gcid (3,2,3) with wrap_lo=101, wrap_hi=000.
  - k=26 gives gcid (1,0,1) with wrap_lo=000, wrap_hi=010.
- Backpressure: i_ready low for 3 cycles during k=5:
  - o_idx=5 and all payload hold for 3 cycles.
  - The sweep completes with exactly 27 accepts and o_done at cycle 31.
- HALF_SHELL_EN defined, DIM=3, GCELL=(2,2,2):
  - The first request is k=13 with gcid (2,2,2).
  - k=14 gives gcid (0,2,2) with wrap_hi=001.
  - 14 accepts, then o_done.
- Reset and ignore:
  - i_start pulsed during ISSUE causes no effect.
  - rst at k=10 drops o_valid with no o_done and returns all outputs to 0.
  - A new i_start restarts at K_FIRST.
- DIM=1, GCELL=0: every request gives gcid (0,0,0), and at k=0 wrap_lo=111.
